// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module  : instr_assembler
// Purpose : Prefetches instruction bytes from a byte-wide memory port into a
//           small queue. It then assembles variable-length instructions
//           (opcode, optional extension byte, optional 8/16-bit little-endian
//           immediate) with help from an external combinational length
//           decoder, and presents each instruction through a valid/ready
//           handshake.
// Ports   : clk, reset_n          - clock, asynchronous active-low reset
//           flush, flush_addr     - discard all state and restart fetch
//           mem_req/addr/ack/data - single-outstanding byte read port
//           dec_opcode/opext      - captured bytes to the length decoder
//           dec_need_opext/need_imm/imm_size/error - decoder classification
//           instr_valid/ready     - output handshake
//           instr_opcode/opext/imm/len/pc/error - assembled instruction
// Rev     : 1.0 - initial release
// ============================================================================
module instr_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic [7:0]            dec_opcode,
  output logic [7:0]            dec_opext,
  input  logic                  dec_need_opext,
  input  logic                  dec_need_imm,
  input  logic                  dec_imm_size,
  input  logic                  dec_error,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic [7:0]            instr_opext,
  output logic [15:0]           instr_imm,
  output logic [2:0]            instr_len,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_error
);

  localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_OP     = 3'd0,
    ST_DEC1   = 3'd1,
    ST_EXT    = 3'd2,
    ST_DEC2   = 3'd3,
    ST_IMM_LO = 3'd4,
    ST_IMM_HI = 3'd5,
    ST_OUT    = 3'd6
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic                    run_q, run_d;            // blocks requests until first edge after reset
  logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d;    // address of the byte at the queue head
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              fifo_q [FIFO_DEPTH];

  logic [7:0]              opcode_q, opcode_d;
  logic [7:0]              opext_q, opext_d;
  logic [15:0]             imm_q, imm_d;
  logic [2:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    err_q, err_d;
  logic                    imm16_q, imm16_d;
  logic                    valid_q, valid_d;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic [7:0]              w_head;

  // --------------------------------------------------------------------------
  // Prefetch queue
  // --------------------------------------------------------------------------
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_FULL);
  // Only one request can be outstanding and the address moves only on an
  // ack, so the address naturally stays put while a request waits.
  assign mem_req = run_q & ~w_full & ~flush;
  assign w_push  = mem_req & mem_ack;
  assign w_head  = fifo_q[rd_ptr_q];

  always_comb begin
    run_d        = 1'b1;
    fetch_addr_d = fetch_addr_q;
    head_pc_d    = head_pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    if (flush) begin
      fetch_addr_d = flush_addr;
      head_pc_d    = flush_addr;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (w_push) begin
        fetch_addr_d = fetch_addr_q + ADDR_ONE;
        wr_ptr_d     = wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        head_pc_d = head_pc_q + ADDR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  // --------------------------------------------------------------------------
  // Assembly FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    opext_d  = opext_q;
    imm_d    = imm_q;
    len_d    = len_q;
    pc_d     = pc_q;
    err_d    = err_q;
    imm16_d  = imm16_q;
    valid_d  = valid_q;
    w_pop    = 1'b0;

    if (flush) begin
      state_d = ST_OP;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_OP: begin
          if (!w_empty) begin
            w_pop    = 1'b1;
            opcode_d = w_head;
            opext_d  = 8'h00;
            imm_d    = 16'h0000;
            len_d    = 3'd1;
            pc_d     = head_pc_q;
            err_d    = 1'b0;
            imm16_d  = 1'b0;
            state_d  = ST_DEC1;
          end
        end
        ST_DEC1: begin
          if (dec_need_opext) begin
            state_d = ST_EXT;
          end else if (dec_error) begin
            err_d   = 1'b1;
            state_d = ST_OUT;
          end else if (dec_need_imm) begin
            imm16_d = dec_imm_size;
            state_d = ST_IMM_LO;
          end else begin
            state_d = ST_OUT;
          end
        end
        ST_EXT: begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            opext_d = w_head;
            len_d   = 3'd2;
            state_d = ST_DEC2;
          end
        end
        ST_DEC2: begin
          // Second classification pass; the opcode's own need_opext is moot now.
          if (dec_error) begin
            err_d   = 1'b1;
            state_d = ST_OUT;
          end else if (dec_need_imm) begin
            imm16_d = dec_imm_size;
            state_d = ST_IMM_LO;
          end else begin
            state_d = ST_OUT;
          end
        end
        ST_IMM_LO: begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            imm_d   = {8'h00, w_head};
            len_d   = len_q + 3'd1;
            state_d = imm16_q ? ST_IMM_HI : ST_OUT;
          end
        end
        ST_IMM_HI: begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            imm_d   = {w_head, imm_q[7:0]};
            len_d   = len_q + 3'd1;
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          // First OUT cycle raises valid; the handshake then returns to OP.
          if (!valid_q) begin
            valid_d = 1'b1;
          end else if (instr_ready) begin
            valid_d = 1'b0;
            state_d = ST_OP;
          end
        end
        default: begin
          state_d = ST_OP;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OP;
      run_q        <= 1'b0;
      fetch_addr_q <= '0;
      head_pc_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      opcode_q     <= 8'h00;
      opext_q      <= 8'h00;
      imm_q        <= 16'h0000;
      len_q        <= 3'd0;
      pc_q         <= '0;
      err_q        <= 1'b0;
      imm16_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      fetch_addr_q <= fetch_addr_d;
      head_pc_q    <= head_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      opcode_q     <= opcode_d;
      opext_q      <= opext_d;
      imm_q        <= imm_d;
      len_q        <= len_d;
      pc_q         <= pc_d;
      err_q        <= err_d;
      imm16_q      <= imm16_d;
      valid_q      <= valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_addr     = fetch_addr_q;
  assign dec_opcode   = opcode_q;
  assign dec_opext    = opext_q;
  assign instr_valid  = valid_q;
  assign instr_opcode = opcode_q;
  assign instr_opext  = opext_q;
  assign instr_imm    = imm_q;
  assign instr_len    = len_q;
  assign instr_pc     = pc_q;
  assign instr_error  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_assembler.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_assembler
// Purpose : Self-checking bench for instr_assembler. A lazily-populated
//           random memory, a small instruction-set decoder and an instruction
//           stream predictor feed an expectation queue; a monitor compares
//           every accepted instruction against it.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [23:0] flush_addr;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  dec_opcode;
  logic [7:0]  dec_opext;
  logic        dec_need_opext;
  logic        dec_need_imm;
  logic        dec_imm_size;
  logic        dec_error;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_opext;
  logic [15:0] instr_imm;
  logic [2:0]  instr_len;
  logic [23:0] instr_pc;
  logic        instr_error;

  instr_assembler #(.FIFO_DEPTH(4), .ADDR_WIDTH(24)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .flush_addr(flush_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .dec_opcode(dec_opcode), .dec_opext(dec_opext),
    .dec_need_opext(dec_need_opext), .dec_need_imm(dec_need_imm),
    .dec_imm_size(dec_imm_size), .dec_error(dec_error),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_opext(instr_opext), .instr_imm(instr_imm),
    .instr_len(instr_len), .instr_pc(instr_pc), .instr_error(instr_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] pc;
    logic [7:0]  op;
    logic [7:0]  ext;
    logic [15:0] imm;
    logic [2:0]  len;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_a [logic [23:0]];
  int          checks   = 0;
  int          failures = 0;
  int          accepted = 0;
  bit          seen_addr0 = 1'b0;

  // Toy instruction set: {need_opext, need_imm, imm16, error}
  function automatic logic [3:0] classify(input logic [7:0] op, input logic [7:0] ext);
    if (op == 8'hCE) begin
      case (ext)
        8'hD0:   return 4'b1110;
        8'hC4:   return 4'b1100;
        8'hEE:   return 4'b1001;
        default: return 4'b1000;
      endcase
    end
    if (op == 8'hFF)          return 4'b0001;
    if (op == 8'hF2)          return 4'b0110;
    if (op[7:3] == 5'b10110)  return 4'b0100;
    return 4'b0000;
  endfunction

  assign {dec_need_opext, dec_need_imm, dec_imm_size, dec_error} = classify(dec_opcode, dec_opext);

  function automatic logic [7:0] gen_byte();
    case ($urandom_range(0, 9))
      0:       return 8'hF8;
      1:       return 8'hF2;
      2:       return 8'hCE;
      3:       return 8'hFF;
      4:       return 8'hB0 | 8'($urandom_range(0, 7));
      5:       return 8'hD0;
      6:       return 8'hC4;
      7:       return 8'hEE;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [23:0] a);
    if (!mem_a.exists(a)) mem_a[a] = gen_byte();
    return mem_a[a];
  endfunction

  // Instruction found at pc, straight from the instruction-set rules.
  function automatic exp_t predict(input logic [23:0] pc);
    exp_t        e;
    logic [3:0]  c;
    logic [23:0] p;
    logic [7:0]  lo;
    logic [7:0]  hi;
    e    = '0;
    e.pc = pc;
    e.op = rd(pc);
    p    = pc + 24'd1;
    if (e.op == 8'hCE) begin
      e.ext = rd(p);
      p     = p + 24'd1;
      c     = classify(e.op, e.ext);
      e.len = 3'd2;
    end else begin
      c     = classify(e.op, 8'h00);
      e.len = 3'd1;
    end
    if (c[0]) begin
      e.err = 1'b1;
    end else if (c[2]) begin
      lo    = rd(p);
      hi    = c[1] ? rd(p + 24'd1) : 8'h00;
      e.imm = {hi, lo};
      e.len = e.len + (c[1] ? 3'd2 : 3'd1);
    end
    return e;
  endfunction

  task automatic predict_from(input logic [23:0] start);
    logic [23:0] pc;
    exp_t        e;
    pc = start;
    for (int i = 0; i < 128; i++) begin
      e = predict(pc);
      sb.push_back(e);
      pc = pc + 24'(e.len);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus. rmode: 0 ready low, 1 ready high, 2 random.
  // amode: 1 ack every request, otherwise random ack.
  task automatic step(input bit fl, input logic [23:0] fa, input int rmode, input int amode);
    @(negedge clk);
    flush       = fl;
    flush_addr  = fa;
    instr_ready = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (fl) begin
      sb.delete();
      predict_from(fa);
      seen_addr0 = 1'b0;
    end
    #1;
    if (fl) begin
      // Stray ack with junk data in the flush cycle must be ignored.
      mem_ack  = 1'b1;
      mem_data = 8'($urandom);
    end else if (mem_req && (amode == 1 || $urandom_range(0, 2) != 0)) begin
      mem_ack  = 1'b1;
      mem_data = rd(mem_addr);
      if (mem_addr == 24'h000000) seen_addr0 = 1'b1;
    end else begin
      mem_ack  = 1'b0;
      mem_data = 8'($urandom);
    end
  endtask

  task automatic post_flush(input logic [23:0] a, input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, {63'd0, instr_valid}, 64'd0);
    chk({tag, "_addr"}, {40'd0, mem_addr}, {40'd0, a});
  endtask

  // Monitor: the handshake completes on the next rising edge.
  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && !flush && instr_valid && instr_ready) begin
        checks++;
        accepted++;
        a = '{pc: instr_pc, op: instr_opcode, ext: instr_opext, imm: instr_imm,
              len: instr_len, err: instr_error};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL instr_unexpected actual pc=%h op=%h len=%0d", instr_pc, instr_opcode, instr_len);
        end else begin
          e = sb.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL instr actual pc=%h op=%h ext=%h imm=%h len=%0d err=%0b required pc=%h op=%h ext=%h imm=%h len=%0d err=%0b",
                     a.pc, a.op, a.ext, a.imm, a.len, a.err, e.pc, e.op, e.ext, e.imm, e.len, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] prog [18] = '{8'hF8, 8'hF2, 8'h34, 8'h12, 8'hCE, 8'hD0, 8'hAA, 8'hBB,
                              8'hCE, 8'hC4, 8'h55, 8'hFF, 8'hCE, 8'hEE, 8'hB3, 8'h77,
                              8'hF8, 8'hF8};
    logic [63:0] snap;
    reset_n     = 1'b0;
    flush       = 1'b0;
    flush_addr  = 24'h0;
    mem_ack     = 1'b0;
    mem_data    = 8'h00;
    instr_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {40'd0, mem_addr}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_error", {63'd0, instr_error}, 64'd0);
    chk("rst_data", {29'd0, instr_opcode, instr_opext, instr_imm, instr_len}, 64'd0);
    chk("rst_pc", {40'd0, instr_pc}, 64'd0);

    for (int i = 0; i < 18; i++) mem_a[24'(i)] = prog[i];
    mem_a[24'h002000] = 8'hF8;
    mem_a[24'h002001] = 8'hF8;
    mem_a[24'h002002] = 8'hF2;
    mem_a[24'h002003] = 8'h34;
    mem_a[24'h002004] = 8'h12;
    predict_from(24'h0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release_no_req", {63'd0, mem_req}, 64'd0);
    @(posedge clk);
    #1;
    chk("first_req", {63'd0, mem_req}, 64'd1);

    // Directed program, ack every cycle, always ready
    repeat (120) step(1'b0, 24'h0, 1, 1);
    // Random ack and ready
    repeat (150) step(1'b0, 24'h0, 2, 2);

    // Backpressure: hold instr_ready low
    step(1'b1, 24'h001000, 0, 1);
    post_flush(24'h001000, "flush1000");
    for (int i = 0; i < 40 && !instr_valid; i++) step(1'b0, 24'h0, 0, 1);
    chk("stall_valid", {63'd0, instr_valid}, 64'd1);
    snap = {instr_valid, instr_opcode, instr_opext, instr_imm, instr_len, instr_pc, instr_error};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 24'h0, 0, 1);
      chk("stall_stable", {instr_valid, instr_opcode, instr_opext, instr_imm, instr_len, instr_pc, instr_error}, snap);
    end
    chk("stall_full_no_req", {63'd0, mem_req}, 64'd0);
    repeat (60) step(1'b0, 24'h0, 2, 2);

    // Flush in the middle of an immediate
    step(1'b1, 24'h002000, 1, 1);
    post_flush(24'h002000, "flush2000");
    for (int i = 0; i < 40 && !(instr_pc == 24'h002002 && !instr_valid); i++) step(1'b0, 24'h0, 1, 1);
    chk("midimm_reached", {40'd0, instr_pc}, 64'h002002);
    step(1'b0, 24'h0, 1, 1);
    step(1'b1, 24'h00FF00, 1, 1);
    post_flush(24'h00FF00, "flushFF00");
    repeat (80) step(1'b0, 24'h0, 2, 2);

    // Address wrap with a 4-byte instruction straddling the top of memory
    mem_a[24'hFFFFFE] = 8'hCE;
    mem_a[24'hFFFFFF] = 8'hD0;
    mem_a[24'h000000] = 8'hAA;
    mem_a[24'h000001] = 8'hBB;
    step(1'b1, 24'hFFFFFE, 2, 2);
    post_flush(24'hFFFFFE, "flushwrap");
    repeat (60) step(1'b0, 24'h0, 2, 2);
    chk("wrap_fetch_addr0", {63'd0, seen_addr0}, 64'd1);

    // Asynchronous reset mid-assembly
    repeat (7) step(1'b0, 24'h0, 2, 2);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_req", {63'd0, mem_req}, 64'd0);
    chk("async_rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("async_rst_addr", {40'd0, mem_addr}, 64'd0);
    mem_ack = 1'b0;
    flush   = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    predict_from(24'h0);
    reset_n = 1'b1;
    #1;
    chk("rerelease_no_req", {63'd0, mem_req}, 64'd0);
    repeat (80) step(1'b0, 24'h0, 2, 2);

    // Random flush targets
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 24'($urandom), 2, 2);
      repeat (40) step(1'b0, 24'h0, 2, 2);
    end

    chk("enough_accepted", {63'd0, (accepted >= 40)}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
